// File: rtl/ofs_plat_csr_responder_pkg.sv
// Shared definitions for the AFU MMIO CSR responder: register word map,
// CSR word type and byte-lane mask expansion.
package ofs_plat_csr_responder_pkg;

  typedef logic [63:0] t_csr_word;

  localparam int CSR_DFH      = 0;
  localparam int CSR_AFU_ID_L = 1;
  localparam int CSR_AFU_ID_H = 2;
  localparam int CSR_RSVD     = 3;
  localparam int CSR_SCRATCH  = 4;
  localparam int CSR_CYCLE    = 5;
  localparam int CSR_EVENT    = 6;
  localparam int CSR_STATUS   = 7;
  localparam int CSR_CTRL     = 8;

  // Expand an 8-bit byteenable into a 64-bit bit mask.
  function automatic t_csr_word byte_mask(input logic [7:0] be);
    t_csr_word m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ofs_plat_csr_read_pipe.sv
// Fixed-latency read response pipeline. Data stages only load when a valid
// response enters them, so the output data holds between responses.
module ofs_plat_csr_read_pipe
  import ofs_plat_csr_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      flush,
  input  logic      in_valid,
  input  t_csr_word in_data,
  output logic      out_valid,
  output t_csr_word out_data
);

  logic [LATENCY-1:0]            vld_pipe_d, vld_pipe_q;
  logic [LATENCY-1:0][63:0]      data_pipe_d, data_pipe_q;

  always_comb begin
    vld_pipe_d     = '0;
    data_pipe_d    = data_pipe_q;
    vld_pipe_d[0]  = in_valid;
    data_pipe_d[0] = in_valid ? in_data : data_pipe_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      data_pipe_d[i] = vld_pipe_q[i-1] ? data_pipe_q[i-1] : data_pipe_q[i];
    end
  end

  // Flush drops in-flight responses and clears the visible data.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign out_valid = vld_pipe_q[LATENCY-1];
  assign out_data  = data_pipe_q[LATENCY-1];

endmodule

// File: rtl/ofs_plat_avalon_mmio_csr_responder.sv
// AFU-side Avalon MMIO (64-bit, word addressed) CSR endpoint: decodes a fixed
// register map and returns read data through a fixed-latency pipeline.
module ofs_plat_avalon_mmio_csr_responder
  import ofs_plat_csr_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 16,
  parameter int          READ_LATENCY    = 1,
  parameter logic [63:0] DFH_VALUE       = 64'h0,
  parameter logic [63:0] AFU_ID_L        = 64'h0,
  parameter logic [63:0] AFU_ID_H        = 64'h0,
  parameter int          NUM_STATUS_BITS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       read,
  input  logic                       write,
  input  logic [63:0]                writedata,
  input  logic [7:0]                 byteenable,
  input  logic                       burstcount,
  output logic                       waitrequest,
  output logic [63:0]                readdata,
  output logic                       readdatavalid,
  input  logic                       event_in,
  input  logic [NUM_STATUS_BITS-1:0] status_set,
  output logic [63:0]                ctrl_out,
  output logic                       protocol_err
);

  logic                       waitrequest_d, waitrequest_q;
  logic                       protocol_err_d, protocol_err_q;
  t_csr_word                  scratch_d, scratch_q;
  t_csr_word                  cycle_d, cycle_q;
  t_csr_word                  event_d, event_q;
  t_csr_word                  ctrl_d, ctrl_q;
  logic [NUM_STATUS_BITS-1:0] status_d, status_q;

  logic      accept, wr_en, rd_en;
  t_csr_word wmask, status_wmask, rd_data;
  logic      sel_scratch, sel_event, sel_status, sel_ctrl;
  logic      unused_sigs;

  assign accept = (read | write) & ~waitrequest_q;
  assign wr_en  = accept & write;
  // A simultaneous read+write performs only the write.
  assign rd_en  = accept & read & ~write;

  assign sel_scratch = (address == ADDR_WIDTH'(CSR_SCRATCH));
  assign sel_event   = (address == ADDR_WIDTH'(CSR_EVENT));
  assign sel_status  = (address == ADDR_WIDTH'(CSR_STATUS));
  assign sel_ctrl    = (address == ADDR_WIDTH'(CSR_CTRL));

  assign wmask        = byte_mask(byteenable);
  assign status_wmask = writedata & wmask;
  assign unused_sigs  = &{1'b0, burstcount, status_wmask};

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_WIDTH'(CSR_DFH):      rd_data = DFH_VALUE;
      ADDR_WIDTH'(CSR_AFU_ID_L): rd_data = AFU_ID_L;
      ADDR_WIDTH'(CSR_AFU_ID_H): rd_data = AFU_ID_H;
      ADDR_WIDTH'(CSR_SCRATCH):  rd_data = scratch_q;
      ADDR_WIDTH'(CSR_CYCLE):    rd_data = cycle_q;
      ADDR_WIDTH'(CSR_EVENT):    rd_data = event_q;
      ADDR_WIDTH'(CSR_STATUS):   rd_data = t_csr_word'(status_q);
      ADDR_WIDTH'(CSR_CTRL):     rd_data = ctrl_q;
      default:                   rd_data = '0;
    endcase
  end

  always_comb begin
    waitrequest_d  = 1'b0;
    protocol_err_d = protocol_err_q | (accept & read & write);
    cycle_d        = cycle_q + 64'd1;

    scratch_d = scratch_q;
    if (wr_en && sel_scratch) scratch_d = (scratch_q & ~wmask) | (writedata & wmask);

    ctrl_d = ctrl_q;
    if (wr_en && sel_ctrl) ctrl_d = (ctrl_q & ~wmask) | (writedata & wmask);

    // Clear-on-read restarts the count with this cycle's event, if any.
    event_d = event_q;
    if (rd_en && sel_event)          event_d = event_in ? 64'd1 : 64'd0;
    else if (event_in && ~&event_q)  event_d = event_q + 64'd1;

    // Set pulses win over a same-cycle W1C.
    status_d = status_q;
    if (wr_en && sel_status) status_d = status_q & ~status_wmask[NUM_STATUS_BITS-1:0];
    status_d = status_d | status_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waitrequest_q  <= 1'b1;
      protocol_err_q <= 1'b0;
      scratch_q      <= '0;
      cycle_q        <= '0;
      event_q        <= '0;
      ctrl_q         <= '0;
      status_q       <= '0;
    end else begin
      waitrequest_q  <= waitrequest_d;
      protocol_err_q <= protocol_err_d;
      scratch_q      <= scratch_d;
      cycle_q        <= cycle_d;
      event_q        <= event_d;
      ctrl_q         <= ctrl_d;
      status_q       <= status_d;
    end
  end

  ofs_plat_csr_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (rd_en),
    .in_data   (rd_data),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

  assign waitrequest  = waitrequest_q;
  assign ctrl_out     = ctrl_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mmio_csr_responder.sv
// Directed bench for the MMIO CSR responder with a 3-cycle read pipeline.
module tb_ofs_plat_avalon_mmio_csr_responder;

  localparam int          RL  = 3;
  localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;
  localparam logic [63:0] IDL = 64'hCAFE_0000_0000_1234;

  logic        clk = 1'b0;
  logic        reset, read, write, burstcount, event_in;
  logic [15:0] address, status_set;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        waitrequest, readdatavalid, protocol_err;
  logic [63:0] readdata, ctrl_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ofs_plat_avalon_mmio_csr_responder #(
    .ADDR_WIDTH(16), .READ_LATENCY(RL), .DFH_VALUE(DFH),
    .AFU_ID_L(IDL), .AFU_ID_H(64'h0), .NUM_STATUS_BITS(16)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .event_in(event_in), .status_set(status_set), .ctrl_out(ctrl_out),
    .protocol_err(protocol_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  // Valid must be low until exactly RL edges after the accepting edge.
  task automatic do_read(input logic [15:0] a, input logic ev, input logic [63:0] exp,
                         input string tag);
    address = a; read = 1'b1; event_in = ev;
    for (int k = 1; k <= RL; k++) begin
      tick();
      if (k == 1) begin read = 1'b0; event_in = 1'b0; end
      chk1({tag, "_vld"}, readdatavalid, k == RL);
    end
    chk64(tag, readdata, exp);
  endtask

  logic [63:0] cyc [3];

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; burstcount = 1'b1; event_in = 1'b0;
    address = '0; status_set = '0; writedata = '0; byteenable = 8'hFF;
    repeat (3) tick();
    chk1("rst_wait", waitrequest, 1'b1);
    chk1("rst_rdv", readdatavalid, 1'b0);
    chk64("rst_rdata", readdata, 64'h0);
    chk64("rst_ctrl", ctrl_out, 64'h0);
    chk1("rst_perr", protocol_err, 1'b0);

    reset = 1'b0;
    #1 chk1("wait_before_edge", waitrequest, 1'b1);
    tick();
    chk1("wait_released", waitrequest, 1'b0);

    do_read(16'd0, 1'b0, DFH, "dfh");
    tick();
    chk1("hold_rdv", readdatavalid, 1'b0);
    chk64("hold_rdata", readdata, DFH);
    do_read(16'd1, 1'b0, IDL, "afu_id_l");
    do_read(16'd3, 1'b0, 64'h0, "rsvd");
    do_read(16'd9, 1'b0, 64'h0, "unmapped");

    do_write(16'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(16'd4, 64'h1122_3344_5566_7788, 8'h0F);
    do_read(16'd4, 1'b0, 64'hFFFF_FFFF_5566_7788, "scratch_be");

    do_write(16'd8, 64'h0123_4567_89AB_CDEF, 8'hC3);
    chk64("ctrl_be", ctrl_out, 64'h0123_0000_0000_CDEF);
    do_write(16'd9, 64'hDEAD, 8'hFF);
    chk64("ctrl_unmapped_wr", ctrl_out, 64'h0123_0000_0000_CDEF);

    event_in = 1'b1;
    repeat (5) tick();
    event_in = 1'b0;
    do_read(16'd6, 1'b1, 64'd5, "event_cor");
    do_read(16'd6, 1'b0, 64'd1, "event_after");

    status_set = 16'h00F0;
    tick();
    status_set = 16'h0010;
    do_write(16'd7, 64'h0030, 8'hFF);
    status_set = 16'h0000;
    do_read(16'd7, 1'b0, 64'h00D0, "status_w1c");

    // Three back-to-back CYCLE reads.
    address = 16'd5; read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) read = 1'b0;
      chk1("b2b_vld", readdatavalid, (k >= RL) && (k <= RL + 2));
      if (k >= RL && k <= RL + 2) cyc[k-RL] = readdata;
    end
    chk64("b2b_step1", cyc[1] - cyc[0], 64'd1);
    chk64("b2b_step2", cyc[2] - cyc[1], 64'd1);

    address = 16'd8; writedata = 64'hA5; byteenable = 8'hFF; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    for (int k = 2; k <= RL + 1; k++) begin
      chk1("rw_no_rdv", readdatavalid, 1'b0);
      tick();
    end
    chk64("rw_ctrl", ctrl_out, 64'hA5);
    chk1("rw_perr", protocol_err, 1'b1);

    // Reset while a read is in flight: its response must never appear.
    address = 16'd0; read = 1'b1;
    tick();
    read = 1'b0; reset = 1'b1;
    for (int k = 1; k <= RL + 1; k++) begin
      tick();
      chk1("flush_no_rdv", readdatavalid, 1'b0);
    end
    chk1("flush_perr", protocol_err, 1'b0);
    chk64("flush_ctrl", ctrl_out, 64'h0);
    chk64("flush_rdata", readdata, 64'h0);
    reset = 1'b0;
    tick();
    do_read(16'd4, 1'b0, 64'h0, "scratch_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
